h_cache_drain_ctrl: RTL and testbench

H_CACHE_DRAIN_CTRL -- requirements
Module: h_cache_drain_ctrl

---
 rtl/h_cache_drain_ctrl.sv | 167 ++++++++++++++++
 tb/tb_h_cache_drain_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/h_cache_drain_ctrl.sv
// Drains the tracking buffer from index 0 up to a start-time snapshot of the write index.
// Reads go through a small credit-limited output FIFO so the consumer can stall.
module h_cache_drain_ctrl #(
    parameter int NUM_ENTRIES = 8192,
    parameter int ENTRY_WIDTH = 64,
    parameter int NUM_IDX_BIT = $clog2(NUM_ENTRIES),
    parameter int RD_LAT      = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [NUM_IDX_BIT-1:0] drain_cnt_o,
    output logic [15:0]            drop_cnt_o,
    input  logic                   trk_wr_en_i,
    output logic                   buf_wr_en_o,
    input  logic [NUM_IDX_BIT-1:0] buf_wr_idx_i,
    input  logic                   buf_overflow_i,
    output logic                   ovf_sticky_o,
    input  logic                   ovf_clr_i,
    output logic                   buf_rd_en_o,
    output logic [NUM_IDX_BIT-1:0] buf_rd_idx_o,
    input  logic [ENTRY_WIDTH-1:0] buf_rd_data_i,
    output logic                   buf_wr_idx_rst_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [ENTRY_WIDTH-1:0] out_data_o,
    output logic                   out_last_o
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_L = (CW+1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_MAX = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RST_IDX, DONE} state_t;

    state_t                 state;
    logic [NUM_IDX_BIT-1:0] cnt_q;
    logic [NUM_IDX_BIT-1:0] issue_idx;
    logic [NUM_IDX_BIT-1:0] start_cnt;
    logic [15:0]            drop_q;
    logic                   ovf_q;
    logic [RD_LAT-1:0]      vld_pipe;
    logic [RD_LAT-1:0]      last_pipe;
    logic [CW-1:0]          inflight;
    logic [CW-1:0]          occ;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [ENTRY_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic                   fifo_last [FIFO_DEPTH];

    logic rd_en;
    logic push;
    logic pop;
    logic issue_last;

    // Handshake: an entry transfers on a rising clk edge where out_valid_o and
    // out_ready_i are both high; out_data_o/out_last_o hold while valid and not ready.
    assign busy_o           = (state != IDLE);
    assign done_o           = (state == DONE);
    assign buf_wr_idx_rst_o = (state == RST_IDX);
    assign buf_wr_en_o      = trk_wr_en_i & ~busy_o;
    assign drain_cnt_o      = cnt_q;
    assign drop_cnt_o       = drop_q;
    assign ovf_sticky_o     = ovf_q;

    // A write landing in the start cycle is counted unless the index is already saturated.
    always_comb begin
        start_cnt = buf_wr_idx_i;
        if (buf_wr_en_o && (buf_wr_idx_i != '1)) start_cnt = buf_wr_idx_i + 1'b1;
    end

    // Reads are only issued when the FIFO is guaranteed a free slot on return.
    assign rd_en = (state == ISSUE) && (issue_idx < cnt_q) &&
                   (({1'b0, inflight} + {1'b0, occ}) < DEPTH_L);
    assign issue_last   = (issue_idx == (cnt_q - 1'b1));
    assign buf_rd_en_o  = rd_en;
    assign buf_rd_idx_o = rd_en ? issue_idx : '0;

    assign push        = vld_pipe[RD_LAT-1];
    assign out_valid_o = (occ != '0);
    assign out_data_o  = fifo_data[rd_ptr];
    assign out_last_o  = out_valid_o & fifo_last[rd_ptr];
    assign pop         = out_valid_o & out_ready_i;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt_q     <= '0;
            issue_idx <= '0;
            drop_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        cnt_q     <= start_cnt;
                        issue_idx <= '0;
                        drop_q    <= '0;
                        state     <= (start_cnt != '0) ? ISSUE : RST_IDX;
                    end
                end
                ISSUE: begin
                    if (rd_en) issue_idx <= issue_idx + 1'b1;
                    if (pop && out_last_o) state <= RST_IDX;
                end
                RST_IDX: state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (trk_wr_en_i && busy_o && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) ovf_q <= 1'b0;
        else if (buf_overflow_i) ovf_q <= 1'b1;
        else if (ovf_clr_i) ovf_q <= 1'b0;
    end

    // Read-latency pipeline carries the valid and last-entry marker alongside the buffer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
            vld_pipe[0]  <= rd_en;
            last_pipe[0] <= rd_en & issue_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inflight <= '0;
            occ      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            case ({rd_en, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (push) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= buf_rd_data_i;
            fifo_last[wr_ptr] <= last_pipe[RD_LAT-1];
        end
    end

endmodule

// File: tb/tb_h_cache_drain_ctrl.sv
// Directed plus randomized drains checked against a queue-based model of the buffer contents.
module tb_h_cache_drain_ctrl;

    localparam int NE = 16;
    localparam int EW = 16;
    localparam int IB = 4;
    localparam int RL = 2;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start_i;
    logic          busy_o;
    logic          done_o;
    logic [IB-1:0] drain_cnt_o;
    logic [15:0]   drop_cnt_o;
    logic          trk_wr_en_i;
    logic          buf_wr_en_o;
    logic [IB-1:0] buf_wr_idx_i;
    logic          buf_overflow_i;
    logic          ovf_sticky_o;
    logic          ovf_clr_i;
    logic          buf_rd_en_o;
    logic [IB-1:0] buf_rd_idx_o;
    logic [EW-1:0] buf_rd_data_i;
    logic          buf_wr_idx_rst_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [EW-1:0] out_data_o;
    logic          out_last_o;

    int tests = 0;
    int fails = 0;

    logic [EW-1:0] mem [NE];
    logic [IB-1:0] rp_idx [RL];

    h_cache_drain_ctrl #(
        .NUM_ENTRIES(NE), .ENTRY_WIDTH(EW), .NUM_IDX_BIT(IB), .RD_LAT(RL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .drain_cnt_o(drain_cnt_o), .drop_cnt_o(drop_cnt_o), .trk_wr_en_i(trk_wr_en_i),
        .buf_wr_en_o(buf_wr_en_o), .buf_wr_idx_i(buf_wr_idx_i), .buf_overflow_i(buf_overflow_i),
        .ovf_sticky_o(ovf_sticky_o), .ovf_clr_i(ovf_clr_i), .buf_rd_en_o(buf_rd_en_o),
        .buf_rd_idx_o(buf_rd_idx_o), .buf_rd_data_i(buf_rd_data_i),
        .buf_wr_idx_rst_o(buf_wr_idx_rst_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_last_o(out_last_o)
    );

    always #5 clk = ~clk;

    // Buffer model: data for a read index appears RL cycles after the read enable.
    always @(posedge clk) begin
        rp_idx[0] <= buf_rd_idx_o;
        for (int i = 1; i < RL; i++) rp_idx[i] <= rp_idx[i-1];
    end
    assign buf_rd_data_i = mem[rp_idx[RL-1]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_drain(input logic [IB-1:0] widx, input bit wr_start,
                             input bit rand_ready, input int n_trk);
        int exp_cnt;
        int exp_drop;
        int rst_cyc;
        int done_cyc;
        int rst_n_seen;
        int done_n_seen;
        bit stall;
        logic [EW-1:0] stall_d;
        logic [EW-1:0] got_d[$];
        bit got_l[$];
        for (int i = 0; i < NE; i++) mem[i] = EW'($urandom);
        exp_cnt = (wr_start && widx != '1) ? int'(widx) + 1 : int'(widx);
        buf_wr_idx_i = widx;
        trk_wr_en_i  = wr_start;
        start_i      = 1'b1;
        #1;
        chk("wr_en_idle", buf_wr_en_o, wr_start);
        tick();
        start_i     = 1'b0;
        trk_wr_en_i = 1'b0;
        chk("busy_after_start", busy_o, 1);
        rst_cyc = -1; done_cyc = -1; rst_n_seen = 0; done_n_seen = 0;
        stall = 1'b0; stall_d = '0; exp_drop = 0;
        for (int cyc = 0; cyc < 400 && done_cyc < 0; cyc++) begin
            out_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            trk_wr_en_i = (cyc < n_trk);
            #1;
            if (trk_wr_en_i) begin
                chk("wr_en_gated", buf_wr_en_o, 0);
                exp_drop++;
            end
            if (stall) begin
                chk("stall_valid", out_valid_o, 1);
                chk("stall_data", out_data_o, stall_d);
            end
            stall   = out_valid_o && !out_ready_i;
            stall_d = out_data_o;
            if (out_valid_o && out_ready_i) begin
                got_d.push_back(out_data_o);
                got_l.push_back(out_last_o);
            end
            if (buf_wr_idx_rst_o) begin rst_n_seen++; rst_cyc = cyc; end
            if (done_o) begin done_n_seen++; done_cyc = cyc; end
            tick();
        end
        trk_wr_en_i = 1'b0;
        out_ready_i = 1'b1;
        chk("done_seen", done_cyc >= 0, 1);
        chk("rst_pulses", rst_n_seen, 1);
        chk("done_pulses", done_n_seen, 1);
        chk("done_after_rst", done_cyc, rst_cyc + 1);
        if (exp_cnt == 0) chk("rst_immediate", rst_cyc, 0);
        chk("entry_count", got_d.size(), exp_cnt);
        for (int i = 0; i < got_d.size() && i < exp_cnt; i++) begin
            chk("entry_data", got_d[i], mem[i]);
            chk("entry_last", got_l[i], (i == exp_cnt - 1));
        end
        chk("drain_cnt", drain_cnt_o, exp_cnt);
        chk("drop_cnt", drop_cnt_o, exp_drop);
        chk("idle_busy", busy_o, 0);
        chk("idle_valid", out_valid_o, 0);
    endtask

    initial begin
        reset_n = 1'b0; start_i = 1'b0; trk_wr_en_i = 1'b0; buf_wr_idx_i = '0;
        buf_overflow_i = 1'b0; ovf_clr_i = 1'b0; out_ready_i = 1'b1;
        for (int i = 0; i < NE; i++) mem[i] = '0;
        tick(); tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_rd_en", buf_rd_en_o, 0);
        chk("rst_idx_rst", buf_wr_idx_rst_o, 0);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_last", out_last_o, 0);
        chk("rst_ovf", ovf_sticky_o, 0);
        chk("rst_drain_cnt", drain_cnt_o, 0);
        chk("rst_drop_cnt", drop_cnt_o, 0);
        chk("rst_rd_idx", buf_rd_idx_o, 0);
        reset_n = 1'b1;
        tick();

        run_drain(4'd3, 1'b0, 1'b0, 0);
        run_drain(4'd0, 1'b0, 1'b0, 0);
        run_drain(4'd5, 1'b1, 1'b0, 4);
        run_drain(4'd8, 1'b0, 1'b1, 0);
        run_drain(4'd15, 1'b1, 1'b1, 2);
        run_drain(4'd15, 1'b0, 1'b0, 0);
        run_drain(4'd1, 1'b0, 1'b1, 1);

        // Abort a drain with reset while the consumer is stalled.
        for (int i = 0; i < NE; i++) mem[i] = EW'($urandom);
        buf_wr_idx_i = 4'd8; out_ready_i = 1'b0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("abort_mid_busy", busy_o, 1);
        chk("abort_mid_valid", out_valid_o, 1);
        reset_n = 1'b0;
        tick();
        chk("abort_busy", busy_o, 0);
        chk("abort_done", done_o, 0);
        chk("abort_rd_en", buf_rd_en_o, 0);
        chk("abort_idx_rst", buf_wr_idx_rst_o, 0);
        chk("abort_valid", out_valid_o, 0);
        chk("abort_last", out_last_o, 0);
        chk("abort_drain_cnt", drain_cnt_o, 0);
        chk("abort_drop_cnt", drop_cnt_o, 0);
        chk("abort_rd_idx", buf_rd_idx_o, 0);
        reset_n = 1'b1; out_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_rst", buf_wr_idx_rst_o, 0);
            chk("abort_no_done", done_o, 0);
            chk("abort_no_valid", out_valid_o, 0);
        end

        // Sticky overflow flag.
        buf_overflow_i = 1'b1;
        tick();
        buf_overflow_i = 1'b0;
        chk("ovf_set", ovf_sticky_o, 1);
        tick(); tick();
        chk("ovf_hold", ovf_sticky_o, 1);
        buf_overflow_i = 1'b1; ovf_clr_i = 1'b1;
        tick();
        buf_overflow_i = 1'b0;
        chk("ovf_set_clr", ovf_sticky_o, 1);
        tick();
        ovf_clr_i = 1'b0;
        chk("ovf_clr", ovf_sticky_o, 0);

        for (int n = 0; n < 8; n++) begin
            run_drain(IB'($urandom_range(0, NE - 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
